// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the scanned 7-segment capture block:
// glyph table, FSM states, digit count and small helpers.
package seg7_capture_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;
   localparam int SMP_W      = NUM_DIGITS + SEG_W;

   // Build-time default polarity of the segment pins
`ifdef SEG7_ACTIVE_LOW
   localparam bit ACTIVE_LOW_DEF = 1'b1;
`else
   localparam bit ACTIVE_LOW_DEF = 1'b0;
`endif

   typedef enum logic {
      ST_TRACK  = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Event output channel of the capture block: valid/ready
// handshake carrying digit index, decoded nibble and error flag.
interface seg7_capture_if;

   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_idx;
   logic [3:0] out_nibble;
   logic       out_err;

   modport master (
      output out_valid,
      output out_idx,
      output out_nibble,
      output out_err,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      input  out_nibble,
      input  out_err,
      output out_ready
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational glyph lookup: normalized 7-bit pattern to hex
// nibble plus a hit flag when the pattern is a known glyph.
module seg7_decode
   import seg7_capture_pkg::*;
(
   input  logic [SEG_W-1:0] pat_i,
   output logic [3:0]       nib_o,
   output logic             hit_o
);

   always_comb begin
      nib_o = 4'd0;
      hit_o = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!hit_o && pat_i == SEG_TABLE[i]) begin
            nib_o = 4'(i);
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Debounced capture of a scanned 4-digit 7-segment display; emits
// one event per newly stable digit value into a 1-deep output slot.
module seg7_capture
   import seg7_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = ACTIVE_LOW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SEG_W-1:0]       seg_in,
   input  logic [NUM_DIGITS-1:0]  dig_en,
   seg7_capture_if.master         ev,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                   overflow
);

   localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

   logic [SEG_W-1:0]        seg_norm;
   logic [SMP_W-1:0]        smp_d, smp_q;
   logic [7:0]              cnt_d, cnt_q;
   state_e                  state_d, state_q;
   logic                    legal, changed, accept;
   logic [1:0]              idx;
   logic [3:0]              dec_nib, cur_nib;
   logic                    dec_hit, event_w;

   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   cap_q;
   logic                    vld_q, err_q, ovf_q;
   logic [1:0]              idx_q;
   logic [3:0]              nib_q;

   assign seg_norm = ACTIVE_LOW ? ~seg_in : seg_in;
   assign smp_d    = {dig_en, seg_norm};
   assign legal    = is_onehot4(dig_en);
   assign changed  = (smp_d != smp_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_TRACK: begin
            if (!legal) begin
               cnt_d = 8'd0;
            end else if (changed) begin
               cnt_d = 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == STABLE_W) begin
                  accept  = 1'b1;
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (changed) begin
               state_d = ST_TRACK;
               cnt_d   = legal ? 8'd1 : 8'd0;
            end
         end
         default: begin
            state_d = ST_TRACK;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_en[i]) idx = 2'(i);
      end
   end

   seg7_decode u_dec (
      .pat_i (seg_norm),
      .nib_o (dec_nib),
      .hit_o (dec_hit)
   );

   assign cur_nib = digits_q[{idx, 2'b00} +: 4];

   // Unknown glyphs always report; known ones only on a new value
   assign event_w = accept &&
      (!dec_hit || !cap_q[idx] || cur_nib != dec_nib);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_q    <= '0;
         cnt_q    <= 8'd0;
         state_q  <= ST_TRACK;
         digits_q <= '0;
         cap_q    <= '0;
         vld_q    <= 1'b0;
         idx_q    <= 2'd0;
         nib_q    <= 4'd0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         smp_q   <= smp_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         if (accept && dec_hit) begin
            digits_q[{idx, 2'b00} +: 4] <= dec_nib;
            cap_q[idx]                  <= 1'b1;
         end
         if (event_w) begin
            if (!vld_q || ev.out_ready) begin
               vld_q <= 1'b1;
               idx_q <= idx;
               nib_q <= dec_hit ? dec_nib : 4'd0;
               err_q <= !dec_hit;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (vld_q && ev.out_ready) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign ev.out_valid  = vld_q;
   assign ev.out_idx    = idx_q;
   assign ev.out_nibble = nib_q;
   assign ev.out_err    = err_q;
   assign digits        = digits_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, single-shot capture,
// bad glyphs, illegal enables, overflow and mid-run reset.
module tb_seg7_capture;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  dig_en;
   logic [15:0] digits;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int nev;

   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G9 = 7'b0011000;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GC = 7'b1000110;

   seg7_capture_if ev_if ();

   seg7_capture #(
      .STABLE_CYCLES (4),
      .ACTIVE_LOW    (1'b0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seg_in   (seg_in),
      .dig_en   (dig_en),
      .ev       (ev_if.master),
      .digits   (digits),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string tag, input logic [1:0] idx,
                         input logic [3:0] nib, input logic err);
      chk({tag, "_valid"}, 32'(ev_if.out_valid), 32'd1);
      chk({tag, "_idx"},   32'(ev_if.out_idx),   32'(idx));
      chk({tag, "_nib"},   32'(ev_if.out_nibble), 32'(nib));
      chk({tag, "_err"},   32'(ev_if.out_err),   32'(err));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(ev_if.out_valid),  32'd0);
      chk({tag, "_idx"},   32'(ev_if.out_idx),    32'd0);
      chk({tag, "_nib"},   32'(ev_if.out_nibble), 32'd0);
      chk({tag, "_err"},   32'(ev_if.out_err),    32'd0);
      chk({tag, "_dig"},   32'(digits),           32'h0);
      chk({tag, "_ovf"},   32'(overflow),         32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      seg_in          = 7'd0;
      dig_en          = 4'd0;
      ev_if.out_ready = 1'b0;
      step(2);
      chk_zero("reset");
      rst = 1'b0;

      // digit 1 shows 5: valid appears in the 5th cycle
      dig_en = 4'b0010;
      seg_in = G5;
      step(3);
      chk("lat_early", 32'(ev_if.out_valid), 32'd0);
      step(1);
      chk_ev("d1_5", 2'd1, 4'h5, 1'b0);
      chk("d1_5_dig", 32'(digits), 32'h0050);

      // keep the same sample: exactly one event delivered
      ev_if.out_ready = 1'b1;
      nev = 0;
      for (int i = 0; i < 20; i++) begin
         if (ev_if.out_valid) nev++;
         step(1);
      end
      chk("single_event", 32'(nev), 32'd1);
      chk("single_valid", 32'(ev_if.out_valid), 32'd0);
      ev_if.out_ready = 1'b0;

      // unknown glyph on digit 0
      dig_en = 4'b0001;
      seg_in = 7'b1111111;
      step(4);
      chk_ev("bad", 2'd0, 4'h0, 1'b1);
      chk("bad_dig", 32'(digits), 32'h0050);
      ev_if.out_ready = 1'b1;
      step(1);
      chk("bad_pop", 32'(ev_if.out_valid), 32'd0);
      ev_if.out_ready = 1'b0;

      // digit 0 shows A
      seg_in = GA;
      step(4);
      chk_ev("d0_A", 2'd0, 4'hA, 1'b0);
      chk("d0_A_dig", 32'(digits), 32'h005A);
      ev_if.out_ready = 1'b1;
      step(1);
      ev_if.out_ready = 1'b0;

      // digit 1 again shows 5: value unchanged, no event
      dig_en = 4'b0010;
      seg_in = G5;
      step(6);
      chk("same_val", 32'(ev_if.out_valid), 32'd0);

      // two enables at once is never accepted
      dig_en = 4'b0110;
      seg_in = G3;
      step(10);
      chk("multi_en", 32'(ev_if.out_valid), 32'd0);
      chk("multi_dig", 32'(digits), 32'h005A);

      // overflow: second event dropped while the first is held
      dig_en = 4'b0100;
      step(4);
      chk_ev("d2_3", 2'd2, 4'h3, 1'b0);
      dig_en = 4'b1000;
      seg_in = GC;
      step(4);
      chk_ev("held", 2'd2, 4'h3, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_dig", 32'(digits), 32'hC35A);

      // handshake and new event in the same cycle
      dig_en = 4'b0001;
      seg_in = G7;
      step(3);
      ev_if.out_ready = 1'b1;
      step(1);
      chk_ev("swap", 2'd0, 4'h7, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("swap_dig", 32'(digits), 32'hC357);
      step(1);
      chk("swap_pop", 32'(ev_if.out_valid), 32'd0);
      ev_if.out_ready = 1'b0;

      // reset in the cycle valid rises
      dig_en = 4'b0100;
      seg_in = G9;
      step(4);
      chk_ev("pre_rst", 2'd2, 4'h9, 1'b0);
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      step(1);
      rst = 1'b0;
      step(3);
      chk("post_early", 32'(ev_if.out_valid), 32'd0);
      step(1);
      chk_ev("post", 2'd2, 4'h9, 1'b0);
      chk("post_dig", 32'(digits), 32'h0900);
      chk("post_ovf", 32'(overflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted (legal range 2..255).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1'b1 when SEG7_ACTIVE_LOW is defined and 1'b0 otherwise, meaning the polarity of seg_in.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port seg_in, input, 7, segment lines of a 4-digit scanned display.
REQ-006 SHALL have port dig_en, input, 4, active-high digit enables (one-hot when legal).
REQ-007 SHALL have port out_ready, input, 1, consumer ready.
REQ-008 SHALL have port out_valid, output, 1, capture event pending.
REQ-009 SHALL have port out_idx, output, 2, digit index of the event.
REQ-010 SHALL have port out_nibble, output, 4, decoded hex value of the event (0 when out_err=1).
REQ-011 SHALL have port out_err, output, 1, event pattern matched no hex glyph.
REQ-012 SHALL have port digits, output, 16, last accepted value per digit; digit i is in bits [4i+3:4i].
REQ-013 SHALL have port overflow, output, 1, sticky flag: an event was dropped.

Function
REQ-014 SHALL normalize each sample as seg_in inverted when ACTIVE_LOW=1, and as seg_in otherwise.
REQ-015 SHALL register {dig_en, normalized seg} every cycle and compare it with the previous registered sample.
REQ-016 SHALL use a 2-state FSM: TRACK, counting consecutive identical legal samples, and LOCKED, where the current sample is already accepted.
REQ-017 SHALL, in TRACK, restart the counter at 1 when the sample changes, and hold it at 0 when dig_en is not one-hot (zero or multiple bits set).
REQ-018 SHALL, in TRACK, accept the sample in the cycle the counter reaches STABLE_CYCLES, then go to LOCKED.
REQ-019 SHALL, in LOCKED, return to TRACK with the counter at 1 on any sample change; a stable sample SHALL never be accepted twice.
REQ-020 SHALL decode on acceptance via the 16-entry normalized table 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL generate an event on a valid acceptance only when the decoded value differs from digits[idx] or the digit has never been captured since reset.
REQ-022 SHALL always generate an event, with out_err=1 and out_nibble=0, on an acceptance whose pattern matches no table entry; digits SHALL be left unchanged in that case.
REQ-023 SHALL update digits[idx] one cycle after acceptance, independently of the handshake.
REQ-024 SHALL place each event in a 1-deep output register; out_valid SHALL rise the cycle after acceptance.
REQ-025 SHALL hold out_valid, out_idx, out_nibble and out_err stable until out_valid and out_ready are both 1.
REQ-026 SHALL, when an event arrives while out_valid=1 and out_ready=0, drop the new event and set overflow.
REQ-027 SHALL, on the handshake and a new event in the same cycle, load the new event with out_valid staying 1 and no overflow.
REQ-028 SHALL keep overflow set until reset.
REQ-029 SHALL have a latency of STABLE_CYCLES+1 cycles from the first cycle of a stable sample at the pins to out_valid.

Reset
REQ-030 SHALL, on rst, immediately clear out_valid, out_idx, out_nibble, out_err, digits, overflow, the counter, the sample register and the captured flags, and enter TRACK.
REQ-031 SHALL discard any pending event on reset mid-operation; the first capture after release SHALL count from zero.

Structure
REQ-032 SHALL keep the segment table constants, the FSM state enum and the digit-count constant (4) in the shared definitions package.
REQ-033 SHALL implement the pattern lookup as the single sub-module seg7_decode (7-bit pattern in, 4-bit nibble and match flag out, combinational).

Verification
REQ-034 Bench SHALL drive dig_en=0010 with the 5 glyph held 4 cycles (STABLE_CYCLES=4) -> out_valid=1 with idx=1, nibble=5, err=0 in cycle 5, and digits[7:4]=5.
REQ-035 Bench SHALL hold the same sample 20 more cycles with out_ready=1 -> exactly one event.
REQ-036 Bench SHALL drive pattern 1111111 stable on digit 0 -> event with err=1 and nibble=0, and digits[3:0] unchanged.
REQ-037 Bench SHALL drive dig_en=0110 stable for 10 cycles -> no event.
REQ-038 Bench SHALL deliver two events to different digits with out_ready=0 -> the first event held, the second dropped, overflow=1.
REQ-039 Bench SHALL assert rst in the cycle out_valid rises -> all outputs 0 immediately, and a fresh capture after release takes the full latency.
